mem_access_unit: RTL and testbench

- MEM-stage initiator for the word-organised data RAM: the pipeline side of the RAM's WD/addr/WE/RD interface.
- Converts a byte-addressed MIPS load/store request (LB, LBU, LH, LHU, LW, SB, SH, SW) into word accesses.
- Sub-word stores use read-modify-write. Misaligned and out-of-range accesses are flagged as faults.
- While a request is in flight, `busy` is asserted so the hazard unit stalls IF/ID/EX.

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-organised data RAM
//
// Turns a byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW request into accesses on a
// word-wide RAM with a combinational read port and a write enable. Sub-word
// stores are done as read-modify-write. Misaligned, out-of-range and
// reserved-size requests complete as faults and never write the RAM.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req_valid        request present; req_* held stable until resp_valid
//   req_write        1 = store, 0 = load
//   req_size         00 byte, 01 halfword, 10 word, 11 reserved (fault)
//   req_signed       loads only: sign-extend (1) or zero-extend (0)
//   req_addr         byte address
//   req_wdata        right-justified store data
//   busy             stall request to IF/ID/EX: req_valid && state != DONE
//   resp_valid       one-cycle completion pulse (registered)
//   resp_rdata       extended load result; 0 for stores and faults
//   resp_fault       fault flag, valid with resp_valid
//   ram_addr         word index (req_addr >> 2)
//   ram_we, ram_wd   RAM write enable and write data
//   ram_rd           RAM read data, combinational in ram_addr

module mem_access_unit #(
  parameter int MEM_WORDS = 100,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMW   = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] merge_q, merge_d;

  logic [ADDR_W-1:0] word_idx;
  logic              misalign;
  logic              range_fault;
  logic              size_fault;
  logic              fault;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_data;
  logic [31:0]       rmw_wd;
  logic              we_c;
  logic [31:0]       wd_c;

  assign word_idx = req_addr >> 2;
  assign ram_addr = word_idx;

  // Fault classification
  assign misalign    = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign range_fault = (word_idx >= ADDR_W'(MEM_WORDS));
  assign size_fault  = (req_size == 2'b11);
  assign fault       = misalign || range_fault || size_fault;

  // Load lane extraction (little-endian lanes) and extension
  always_comb begin
    lane_byte = ram_rd[7:0];
    case (req_addr[1:0])
      2'd0: lane_byte = ram_rd[7:0];
      2'd1: lane_byte = ram_rd[15:8];
      2'd2: lane_byte = ram_rd[23:16];
      2'd3: lane_byte = ram_rd[31:24];
      default: lane_byte = ram_rd[7:0];
    endcase
    lane_half = req_addr[1] ? ram_rd[31:16] : ram_rd[15:0];
  end

  always_comb begin
    load_data = ram_rd;
    case (req_size)
      SZ_BYTE: load_data = req_signed ? {{24{lane_byte[7]}}, lane_byte}
                                      : {24'h0, lane_byte};
      SZ_HALF: load_data = req_signed ? {{16{lane_half[15]}}, lane_half}
                                      : {16'h0, lane_half};
      default: load_data = ram_rd;
    endcase
  end

  // Write-back word: the latched original with only the addressed lane replaced
  always_comb begin
    rmw_wd = merge_q;
    if (req_size == SZ_HALF) begin
      if (req_addr[1]) rmw_wd[31:16] = req_wdata[15:0];
      else             rmw_wd[15:0]  = req_wdata[15:0];
    end else begin
      case (req_addr[1:0])
        2'd0: rmw_wd[7:0]   = req_wdata[7:0];
        2'd1: rmw_wd[15:8]  = req_wdata[7:0];
        2'd2: rmw_wd[23:16] = req_wdata[7:0];
        2'd3: rmw_wd[31:24] = req_wdata[7:0];
        default: rmw_wd = merge_q;
      endcase
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = 32'h0;
    merge_d      = merge_q;
    we_c         = 1'b0;
    wd_c         = req_wdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          if (fault) begin
            resp_fault_d = 1'b1;
          end else if (!req_write) begin
            resp_rdata_d = load_data;
          end else if (req_size == SZ_WORD) begin
            we_c = 1'b1;
          end else begin
            // Sub-word store: hold the original word, write it back next cycle
            merge_d      = ram_rd;
            state_d      = RMW;
            resp_valid_d = 1'b0;
          end
        end
      end
      RMW: begin
        // Completes even if req_valid has dropped
        we_c         = 1'b1;
        wd_c         = rmw_wd;
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      merge_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      merge_q      <= merge_d;
    end
  end

  // Reset in the RMW cycle must suppress the write-back immediately
  assign ram_we     = we_c && !rst;
  assign ram_wd     = wd_c;
  assign busy       = req_valid && (state_q != DONE);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  logic [31:0] mem [0:99];
  logic        bd_we;
  int          bd_addr;
  logic [31:0] bd_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.MEM_WORDS(100), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wd    (ram_wd),
    .ram_rd    (ram_rd)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge; bench backdoor for preload
  assign ram_rd = (ram_addr < 32'd100) ? mem[ram_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we && (ram_addr < 32'd100)) mem[ram_addr[6:0]] <= ram_wd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #2;
    bd_we = 1'b0;
  endtask

  // One request from IDLE to completion; latency counts the request cycle as 1
  task automatic run_op(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat,
                        input int exp_we_cyc, input logic [31:0] exp_wd);
    int cyc, we_cnt, we_cyc;
    logic [31:0] we_data;
    bit got;
    cyc = 1; we_cnt = 0; we_cyc = 0; we_data = 32'h0; got = 0;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    chk({tag, " busy_req"}, busy, 1);
    while (!got && cyc < 6) begin
      if (ram_we) begin we_cnt++; we_cyc = cyc; we_data = ram_wd; end
      @(posedge clk); #2;
      cyc++;
      if (resp_valid) got = 1;
    end
    if (!got) cyc = 0;
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " fault"}, resp_fault, exp_flt);
    chk({tag, " busy_done"}, busy, 0);
    chk({tag, " we_count"}, we_cnt, (exp_we_cyc != 0) ? 1 : 0);
    chk({tag, " we_cycle"}, we_cyc, exp_we_cyc);
    if (exp_we_cyc != 0) chk({tag, " wd"}, we_data, exp_wd);
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk({tag, " pulse_end"}, resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int bad;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bd_we = 1'b0; bd_addr = 0; bd_data = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset resp_fault", resp_fault, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    poke(0, 32'hCAFEF00D);
    poke(1, 32'h01020304);
    poke(2, 32'h00000000);
    poke(3, 32'h8899AABB);
    poke(5, 32'h11223344);
    poke(99, 32'h99999999);

    // No request: no write, no response
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (ram_we || resp_valid) bad++;
      @(posedge clk); #2;
    end
    chk("idle no activity", bad, 0);
    chk("idle mem0", mem[0], 32'hCAFEF00D);

    // Loads with extension
    run_op("LB 0D",  0, 2'b00, 1, 32'h0D, 0, 32'hFFFFFFAA, 0, 2, 0, 0);
    run_op("LBU 0D", 0, 2'b00, 0, 32'h0D, 0, 32'h000000AA, 0, 2, 0, 0);
    run_op("LB 0C",  0, 2'b00, 1, 32'h0C, 0, 32'h000000BB - 32'h0 | 32'hFFFFFF00, 0, 2, 0, 0);
    run_op("LH 0E",  0, 2'b01, 1, 32'h0E, 0, 32'hFFFF8899, 0, 2, 0, 0);
    run_op("LHU 0E", 0, 2'b01, 0, 32'h0E, 0, 32'h00008899, 0, 2, 0, 0);
    run_op("LW sgn", 0, 2'b10, 1, 32'h0C, 0, 32'h8899AABB, 0, 2, 0, 0);
    run_op("LW 18C", 0, 2'b10, 0, 32'h18C, 0, 32'h99999999, 0, 2, 0, 0);

    // Halfword RMW store
    run_op("SH 16", 1, 2'b01, 0, 32'h16, 32'h0000BEEF, 32'h0, 0, 3, 2, 32'hBEEF3344);
    chk("SH mem5", mem[5], 32'hBEEF3344);
    run_op("LW 14", 0, 2'b10, 0, 32'h14, 0, 32'hBEEF3344, 0, 2, 0, 0);

    // Word store
    run_op("SW 08", 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF);
    chk("SW mem2", mem[2], 32'hDEADBEEF);
    run_op("LW 08", 0, 2'b10, 0, 32'h08, 0, 32'hDEADBEEF, 0, 2, 0, 0);

    // Faults
    run_op("LH 03 flt",  0, 2'b01, 1, 32'h03, 0, 32'h0, 1, 2, 0, 0);
    run_op("SW 06 flt",  1, 2'b10, 0, 32'h06, 32'h12345678, 32'h0, 1, 2, 0, 0);
    chk("SW flt mem1", mem[1], 32'h01020304);
    run_op("LW 190 flt", 0, 2'b10, 0, 32'h190, 0, 32'h0, 1, 2, 0, 0);
    run_op("SZ11 ld flt", 0, 2'b11, 0, 32'h0C, 0, 32'h0, 1, 2, 0, 0);
    run_op("SZ11 st flt", 1, 2'b11, 0, 32'h00, 32'h55555555, 32'h0, 1, 2, 0, 0);
    chk("SZ11 mem0", mem[0], 32'hCAFEF00D);
    run_op("SB 190 flt", 1, 2'b00, 0, 32'h190, 32'h77, 32'h0, 1, 2, 0, 0);

    // Reset during the RMW write-back cycle
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h04;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #2;
    chk("rst rmw we_pre", ram_we, 1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rst rmw we_gated", ram_we, 0);
    @(posedge clk); #2;
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_fault", resp_fault, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst busy", busy, 0);
    chk("rst mem1", mem[1], 32'h01020304);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst after resp_valid", resp_valid, 0);

    // Back-to-back LW with req_valid held
    pulses = 0;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h00;
    req_valid = 1'b1;
    #1;
    chk("b2b busy1", busy, 1);
    if (resp_valid) pulses++;
    @(posedge clk); #2;
    chk("b2b busy2", busy, 0);
    chk("b2b rdata0", resp_rdata, 32'hCAFEF00D);
    if (resp_valid) pulses++;
    req_addr = 32'h04;
    @(posedge clk); #2;
    chk("b2b busy3", busy, 1);
    if (resp_valid) pulses++;
    @(posedge clk); #2;
    chk("b2b busy4", busy, 0);
    chk("b2b rdata1", resp_rdata, 32'h01020304);
    if (resp_valid) pulses++;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      if (resp_valid) pulses++;
    end
    chk("b2b pulses", pulses, 2);

    // Byte RMW store into lane 1
    run_op("SB 05", 1, 2'b00, 0, 32'h05, 32'hFFFFFF77, 32'h0, 0, 3, 2, 32'h01027704);
    chk("SB mem1", mem[1], 32'h01027704);
    run_op("LBU 05", 0, 2'b00, 0, 32'h05, 0, 32'h00000077, 0, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
